// File: rtl/dht11_pkg.sv
`timescale 1ns/1ps
// Shared DHT11 definitions: FSM states, phase lengths in microseconds and frame helpers.
// Used by both the sensor-side responder and the host-side reader.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOST_LOW,
    ST_RESP_DELAY,
    ST_RESP_LOW,
    ST_RESP_HIGH,
    ST_BIT_LOW,
    ST_BIT_HIGH,
    ST_END_LOW
  } dht11_state_t;

  localparam int RESP_DELAY_US = 30;
  localparam int RESP_LOW_US   = 80;
  localparam int RESP_HIGH_US  = 80;
  localparam int BIT_LOW_US    = 50;
  localparam int BIT0_HIGH_US  = 26;
  localparam int BIT1_HIGH_US  = 70;
  localparam int END_LOW_US    = 50;
  localparam int FRAME_BITS    = 40;

  function automatic int bit_high_us(input logic i_Bit);
    return i_Bit ? BIT1_HIGH_US : BIT0_HIGH_US;
  endfunction

  // Sum is formed wide so the carry is explicit, then truncated to the byte on the wire.
  function automatic logic [7:0] frame_checksum(input logic [7:0] i_A, input logic [7:0] i_B,
                                                input logic [7:0] i_C, input logic [7:0] i_D);
    logic [9:0] w_Sum;
    w_Sum = 10'(i_A) + 10'(i_B) + 10'(i_C) + 10'(i_D);
    return w_Sum[7:0];
  endfunction

endpackage

// File: rtl/dht11_us_tick.sv
`timescale 1ns/1ps
// One-microsecond tick prescaler; i_Clr restarts the count so each phase starts
// on a fresh microsecond boundary.
module dht11_us_tick #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic i_Clk,
  input  logic i_Rst_n,
  input  logic i_Clr,
  output logic o_Tick
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_Cnt;
  logic          w_Wrap;

  assign w_Wrap = (r_Cnt == LAST);
  assign o_Tick = w_Wrap && !i_Clr;

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Cnt <= '0;
    end else if (i_Clr || w_Wrap) begin
      r_Cnt <= '0;
    end else begin
      r_Cnt <= r_Cnt + 1'b1;
    end
  end

endmodule

// File: rtl/dht11_responder.sv
`timescale 1ns/1ps
// Sensor-side DHT11 emulator: detects the host start pulse on the open-drain line and
// answers with the response preamble plus 40 data bits through an external pad buffer.
module dht11_responder
  import dht11_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int START_MIN_US = 18000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Line,
  input  logic       i_Enable,
  input  logic [7:0] i_Hum_Int,
  input  logic [7:0] i_Hum_Dec,
  input  logic [7:0] i_Tmp_Int,
  input  logic [7:0] i_Tmp_Dec,
  output logic       o_Dir,
  output logic       o_Send,
  output logic       o_Busy,
  output logic       o_Done,
  output logic       o_Abort,
  output logic [7:0] o_Checksum
);

  localparam int US_BITS = $clog2(START_MIN_US + 1) + 1;
  localparam int US_W    = (US_BITS > 8) ? US_BITS : 8;
  localparam logic [US_W-1:0] START_MIN   = US_W'(START_MIN_US);
  // Our own low drive is still visible through the synchronizer for a few cycles
  // after release, so host interference is only judged once this much time has passed.
  localparam logic [US_W-1:0] ABORT_BLANK = US_W'(2);

  logic                  r_Meta;
  logic                  r_Sync;
  dht11_state_t          r_State;
  logic [US_W-1:0]       r_Us;
  logic                  r_Clr;
  logic                  r_Armed;
  logic [FRAME_BITS-1:0] r_Shift;
  logic [5:0]            r_Bits;
  logic                  r_Dir;
  logic                  r_Busy;
  logic                  r_Done;
  logic                  r_Abort;
  logic [7:0]            r_Checksum;

  logic                  w_Tick;
  logic [US_W-1:0]       w_Lim;
  logic                  w_End;
  logic                  w_Interfere;
  logic [7:0]            w_Sum;

  dht11_us_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .i_Clk   (i_Clk),
    .i_Rst_n (i_Rst_n),
    .i_Clr   (r_Clr),
    .o_Tick  (w_Tick)
  );

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_Meta <= 1'b1;
      r_Sync <= 1'b1;
    end else begin
      r_Meta <= i_Line;
      r_Sync <= r_Meta;
    end
  end

  assign w_Sum = frame_checksum(i_Hum_Int, i_Hum_Dec, i_Tmp_Int, i_Tmp_Dec);

  always_comb begin
    w_Lim = '0;
    case (r_State)
      ST_RESP_DELAY: w_Lim = US_W'(RESP_DELAY_US - 1);
      ST_RESP_LOW:   w_Lim = US_W'(RESP_LOW_US - 1);
      ST_RESP_HIGH:  w_Lim = US_W'(RESP_HIGH_US - 1);
      ST_BIT_LOW:    w_Lim = US_W'(BIT_LOW_US - 1);
      ST_BIT_HIGH:   w_Lim = US_W'(bit_high_us(r_Shift[FRAME_BITS-1]) - 1);
      ST_END_LOW:    w_Lim = US_W'(END_LOW_US - 1);
      default:       w_Lim = '0;
    endcase
  end

  assign w_End       = w_Tick && (r_Us == w_Lim);
  assign w_Interfere = !r_Sync && (r_Us >= ABORT_BLANK);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      r_State    <= ST_IDLE;
      r_Us       <= '0;
      r_Clr      <= 1'b0;
      r_Armed    <= 1'b0;
      r_Shift    <= '0;
      r_Bits     <= '0;
      r_Dir      <= 1'b0;
      r_Busy     <= 1'b0;
      r_Done     <= 1'b0;
      r_Abort    <= 1'b0;
      r_Checksum <= '0;
    end else begin
      r_Clr   <= 1'b0;
      r_Done  <= 1'b0;
      r_Abort <= 1'b0;
      if (w_Tick && (r_Us != '1)) begin
        r_Us <= r_Us + 1'b1;
      end

      case (r_State)
        // A start is only accepted after the line has been seen released in IDLE.
        ST_IDLE: begin
          if (r_Sync) begin
            r_Armed <= 1'b1;
          end else if (r_Armed && i_Enable) begin
            r_State <= ST_HOST_LOW;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end
        end

        ST_HOST_LOW: begin
          if (r_Sync) begin
            r_Us  <= '0;
            r_Clr <= 1'b1;
            if (r_Us >= START_MIN) begin
              r_State    <= ST_RESP_DELAY;
              r_Busy     <= 1'b1;
              r_Shift    <= {i_Hum_Int, i_Hum_Dec, i_Tmp_Int, i_Tmp_Dec, w_Sum};
              r_Checksum <= w_Sum;
              r_Bits     <= 6'(FRAME_BITS);
            end else begin
              r_State <= ST_IDLE;
              r_Armed <= 1'b0;
            end
          end
        end

        ST_RESP_DELAY: begin
          if (w_End) begin
            r_State <= ST_RESP_LOW;
            r_Dir   <= 1'b1;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end
        end

        ST_RESP_LOW: begin
          if (w_End) begin
            r_State <= ST_RESP_HIGH;
            r_Dir   <= 1'b0;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end
        end

        ST_RESP_HIGH: begin
          if (w_Interfere) begin
            r_State <= ST_IDLE;
            r_Busy  <= 1'b0;
            r_Abort <= 1'b1;
            r_Armed <= 1'b0;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end else if (w_End) begin
            r_State <= ST_BIT_LOW;
            r_Dir   <= 1'b1;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end
        end

        ST_BIT_LOW: begin
          if (w_End) begin
            r_State <= ST_BIT_HIGH;
            r_Dir   <= 1'b0;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end
        end

        // High width encodes the MSB of the shift register; the shift happens as it ends.
        ST_BIT_HIGH: begin
          if (w_Interfere) begin
            r_State <= ST_IDLE;
            r_Busy  <= 1'b0;
            r_Abort <= 1'b1;
            r_Armed <= 1'b0;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end else if (w_End) begin
            r_Shift <= {r_Shift[FRAME_BITS-2:0], 1'b0};
            r_Bits  <= r_Bits - 1'b1;
            r_Dir   <= 1'b1;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
            r_State <= (r_Bits == 6'd1) ? ST_END_LOW : ST_BIT_LOW;
          end
        end

        ST_END_LOW: begin
          if (w_End) begin
            r_State <= ST_IDLE;
            r_Dir   <= 1'b0;
            r_Busy  <= 1'b0;
            r_Done  <= 1'b1;
            r_Armed <= 1'b0;
            r_Us    <= '0;
            r_Clr   <= 1'b1;
          end
        end

        default: begin
          r_State <= ST_IDLE;
          r_Dir   <= 1'b0;
          r_Busy  <= 1'b0;
          r_Armed <= 1'b0;
        end
      endcase
    end
  end

  assign o_Dir      = r_Dir;
  assign o_Send     = 1'b0;
  assign o_Busy     = r_Busy;
  assign o_Done     = r_Done;
  assign o_Abort    = r_Abort;
  assign o_Checksum = r_Checksum;

endmodule
